// File: rtl/miriscv_instr_mem_responder.sv
// Instruction memory with a fixed-latency request/response fetch port and a loader write port.
// Define MIRISCV_IMEM_ERR_EN to add instr_err_o and range-check fetches and loader writes.
module miriscv_instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int unsigned XLEN       = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
`ifdef MIRISCV_IMEM_ERR_EN
  output logic            instr_err_o,
`endif
  input  logic            load_we_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic [31:0]     load_wdata_i
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_ok;
  logic        wr_ok;
  logic        enter_resp;

  // Offset from the base, then drop the byte lane; upper bits alias.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef MIRISCV_IMEM_ERR_EN
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (AW + 2)) == 32'd0);
  endfunction

  logic err_q;
  assign instr_err_o = err_q;
`endif

  // With LATENCY=1 the read happens on the accepting edge, so use the live address.
  always_comb begin
    rd_addr = (state_q == StIdle) ? instr_addr_i : addr_q;
    rd_word = mem_q[word_idx(rd_addr)];
`ifdef MIRISCV_IMEM_ERR_EN
    rd_ok = in_range(rd_addr);
    wr_ok = in_range(load_addr_i);
`else
    rd_ok = 1'b1;
    wr_ok = 1'b1;
`endif
    enter_resp = ((state_q == StIdle) && instr_req_i && (LATENCY == 1)) ||
                 ((state_q == StWait) && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= Nop;
`ifdef MIRISCV_IMEM_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= enter_resp;
`ifdef MIRISCV_IMEM_ERR_EN
      err_q    <= enter_resp && !rd_ok;
`endif
      if (enter_resp) begin
        rdata_q <= rd_ok ? rd_word : Nop;
      end
      case (state_q)
        StIdle: begin
          if (instr_req_i) begin
            addr_q <= instr_addr_i;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is never reset; loader is inert while reset is held.
  always_ff @(posedge clk_i) begin
    if (arstn_i && load_we_i && wr_ok) begin
      mem_q[word_idx(load_addr_i)] <= load_wdata_i;
    end
  end

  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;

endmodule

// File: tb/tb_miriscv_instr_mem_responder.sv
// Directed bench: a LATENCY=1 instance (default depth, base 0) and a LATENCY=3 instance
// (16 words at base 0x100) sharing reset and the loader bus.
module tb_miriscv_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;

  logic        req1, rvalid1;
  logic [31:0] addr1, rdata1;
  logic        req3, rvalid3;
  logic [31:0] addr3, rdata3;
`ifdef MIRISCV_IMEM_ERR_EN
  logic        err1, err3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  miriscv_instr_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (1),
    .BASE_ADDR  (32'h0000_0000)
  ) u_dut_l1 (
    .clk_i         (clk),
    .arstn_i       (rst_n),
    .instr_req_i   (req1),
    .instr_addr_i  (addr1),
    .instr_rvalid_o(rvalid1),
    .instr_rdata_o (rdata1),
`ifdef MIRISCV_IMEM_ERR_EN
    .instr_err_o   (err1),
`endif
    .load_we_i     (ld_we),
    .load_addr_i   (ld_addr),
    .load_wdata_i  (ld_wdata)
  );

  miriscv_instr_mem_responder #(
    .DEPTH_WORDS(16),
    .LATENCY    (3),
    .BASE_ADDR  (32'h0000_0100)
  ) u_dut_l3 (
    .clk_i         (clk),
    .arstn_i       (rst_n),
    .instr_req_i   (req3),
    .instr_addr_i  (addr3),
    .instr_rvalid_o(rvalid3),
    .instr_rdata_o (rdata3),
`ifdef MIRISCV_IMEM_ERR_EN
    .instr_err_o   (err3),
`endif
    .load_we_i     (ld_we),
    .load_addr_i   (ld_addr),
    .load_wdata_i  (ld_wdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we    = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    tick();
    ld_we    = 1'b0;
  endtask

  // One-cycle request on the LATENCY=3 port; the address is disturbed after acceptance.
  task automatic l3_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input logic exp_err);
    req3  = 1'b1;
    addr3 = a;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        req3  = 1'b0;
        addr3 = a ^ 32'h0000_0004;
      end
      check($sformatf("%s_rv%0d", tag, k), {31'd0, rvalid3}, {31'd0, (k == 3)});
      if (k == 3) begin
        check({tag, "_data"}, rdata3, exp);
`ifdef MIRISCV_IMEM_ERR_EN
        check({tag, "_err"}, {31'd0, err3}, {31'd0, exp_err});
`endif
      end
    end
  endtask

  initial begin
    logic exp_rv;
    rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    req1 = 1'b0; addr1 = '0; req3 = 1'b0; addr3 = '0;
    repeat (3) tick();
    check("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    check("rst_rdata1", rdata1, 32'h0000_0013);
    check("rst_rvalid3", {31'd0, rvalid3}, 32'd0);
    check("rst_rdata3", rdata3, 32'h0000_0013);
`ifdef MIRISCV_IMEM_ERR_EN
    check("rst_err3", {31'd0, err3}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    load(32'h0000_0000, 32'h0040_0093);
    load(32'h0000_0004, 32'h1111_1111);
    load(32'h0000_0108, 32'h2222_2222);
    load(32'h0000_010C, 32'h3333_3333);

    // LATENCY=1 single fetch
    req1 = 1'b1; addr1 = 32'h0;
    check("l1_pre_rvalid", {31'd0, rvalid1}, 32'd0);
    tick();
    req1 = 1'b0;
    check("l1_rvalid", {31'd0, rvalid1}, 32'd1);
    check("l1_rdata", rdata1, 32'h0040_0093);
    tick();
    check("l1_rvalid_off", {31'd0, rvalid1}, 32'd0);
    check("l1_rdata_hold", rdata1, 32'h0040_0093);

    // Byte offset bits are ignored
    req1 = 1'b1; addr1 = 32'h6;
    tick();
    req1 = 1'b0;
    check("l1_offset_rdata", rdata1, 32'h1111_1111);
    tick();

    // Loader write on the same edge as the read returns old data
    req1 = 1'b1; addr1 = 32'h4;
    ld_we = 1'b1; ld_addr = 32'h4; ld_wdata = 32'hDEAD_BEEF;
    tick();
    req1 = 1'b0; ld_we = 1'b0;
    check("raw_rvalid", {31'd0, rvalid1}, 32'd1);
    check("raw_old", rdata1, 32'h1111_1111);
    tick();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check("raw_new", rdata1, 32'hDEAD_BEEF);
    tick();

    // Held request at LATENCY=1: strobe every other cycle
    req1 = 1'b1; addr1 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("l1_held_%0d", i), {31'd0, rvalid1}, {31'd0, (i % 2 == 0)});
    end
    req1 = 1'b0;
    tick();

    // Held request at LATENCY=3: strobes 3 and 7 cycles after first sample
    req3 = 1'b1; addr3 = 32'h0000_0108;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) req3 = 1'b0;
      exp_rv = (k == 3) || (k == 7);
      check($sformatf("l3_held_%0d", k), {31'd0, rvalid3}, {31'd0, exp_rv});
      if (k == 3) check("l3_held_data", rdata3, 32'h2222_2222);
    end

    l3_fetch("l3_pulse", 32'h0000_010C, 32'h3333_3333, 1'b0);
`ifdef MIRISCV_IMEM_ERR_EN
    l3_fetch("l3_oor", 32'h0000_0148, 32'h0000_0013, 1'b1);
`else
    l3_fetch("l3_alias", 32'h0000_0148, 32'h2222_2222, 1'b0);
`endif

    // Reset while in WAIT aborts the fetch; loader write under reset is dropped
    req3 = 1'b1; addr3 = 32'h0000_010C;
    tick();
    req3 = 1'b0;
    tick();
    rst_n = 1'b0;
    ld_we = 1'b1; ld_addr = 32'h0000_010C; ld_wdata = 32'hBAD0_BAD0;
    tick();
    check("wrst_rvalid", {31'd0, rvalid3}, 32'd0);
    check("wrst_rdata", rdata3, 32'h0000_0013);
    check("wrst_rdata1", rdata1, 32'h0000_0013);
    rst_n = 1'b1; ld_we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("wrst_quiet_%0d", k), {31'd0, rvalid3}, 32'd0);
    end
    l3_fetch("l3_after_rst", 32'h0000_010C, 32'h3333_3333, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/miriscv_instr_mem_responder.md
MIRISCV_INSTR_MEM_RESPONDER -- requirements
Module: miriscv_instr_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 4..65536.
REQ-002 The block SHALL have parameter LATENCY, default 1: cycles from request acceptance to response; legal range 1..15.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-004 The block SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port arstn_i, input, 1: reset; synchronous and active-low.
REQ-006 The block SHALL have port instr_req_i, input, 1: fetch request; held high by the initiator until a response is seen.
REQ-007 The block SHALL have port instr_addr_i, input, XLEN: byte address of the requested instruction.
REQ-008 The block SHALL have port instr_rvalid_o, output, 1: one-cycle response strobe.
REQ-009 The block SHALL have port instr_rdata_o, output, XLEN: instruction word; valid while instr_rvalid_o is high.
REQ-010 The block SHALL have port load_we_i, input, 1: loader write enable.
REQ-011 The block SHALL have port load_addr_i, input, XLEN: loader byte address.
REQ-012 The block SHALL have port load_wdata_i, input, 32: loader write data.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 In IDLE with instr_req_i=1, the block SHALL capture instr_addr_i and go to RESP when LATENCY=1, else go to WAIT with counter=LATENCY-2.
REQ-015 In WAIT, the block SHALL decrement the counter each cycle and go to RESP in the cycle after the counter reads 0.
REQ-016 In RESP, the block SHALL drive instr_rvalid_o=1 for exactly one cycle, then return to IDLE.
REQ-017 Cycle timing SHALL be: request sampled in cycle N gives instr_rvalid_o high in cycle N+LATENCY.
REQ-018 RESP SHALL never go directly to WAIT or RESP; there are no back-to-back strobes, and a request held through RESP is re-accepted in the next IDLE cycle.
REQ-019 The block SHALL ignore instr_req_i and instr_addr_i in WAIT and RESP; once accepted, a transaction always completes, even if instr_req_i drops (kill or stall at the initiator).
REQ-020 Word index SHALL be (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits; addr[1:0] is ignored.
REQ-021 The memory read SHALL be registered; it occurs on the edge entering RESP, and instr_rdata_o holds that word until the next response.
REQ-022 A loader write SHALL update the array on the edge where load_we_i=1, in any FSM state.
REQ-023 A loader write to the word being read on the same edge SHALL leave old data on instr_rdata_o.
REQ-024 Outside RESP, instr_rvalid_o SHALL be 0 and instr_rdata_o SHALL hold its last value.

Reset
REQ-025 With arstn_i=0 at a clock edge, the block SHALL enter IDLE, clear the counter, and set instr_rvalid_o=0 and instr_rdata_o=32'h0000_0013 (NOP).
REQ-026 A reset during WAIT or RESP SHALL abort the transaction with no strobe.
REQ-027 Array contents SHALL NOT be reset, and loader writes SHALL be ignored while arstn_i=0.

Configuration
REQ-028 When macro MIRISCV_IMEM_ERR_EN is defined, the block SHALL add output port instr_err_o (1 bit).
REQ-029 With MIRISCV_IMEM_ERR_EN defined, a fetch with addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH_WORDS*4 SHALL get instr_err_o=1 together with instr_rvalid_o and instr_rdata_o=32'h0000_0013, with the same latency as a normal fetch.
REQ-030 With MIRISCV_IMEM_ERR_EN defined, an out-of-range loader write SHALL be dropped, and instr_err_o SHALL be 0 at reset and outside RESP.
REQ-031 Without MIRISCV_IMEM_ERR_EN, the port SHALL be absent and out-of-range addresses SHALL alias per REQ-020 for both reads and writes.

Verification
REQ-032 Scenario: LATENCY=1, load word 0 = 32'h0040_0093, req at addr 0 in cycle 5 -> rvalid=1 in cycle 6 only, rdata=32'h0040_0093.
REQ-033 Scenario: LATENCY=3, req held high from cycle 10 -> rvalid in cycles 13 and 17 only, and in no other cycle.
REQ-034 Scenario: LATENCY=4, req pulsed only in cycle 2 (addr 8) -> rvalid in cycle 6 with word 2; req low afterwards gives no further strobes.
REQ-035 Scenario: loader writes word 1 = 32'hDEAD_BEEF on the same edge a read of addr 4 enters RESP -> rdata = old value; a following fetch of addr 4 returns 32'hDEAD_BEEF.
REQ-036 Scenario: reset pulsed in WAIT (LATENCY=5) -> no rvalid, rdata=32'h13, FSM in IDLE; a new request completes normally.
REQ-037 Scenario: MIRISCV_IMEM_ERR_EN defined, DEPTH_WORDS=1024, fetch addr 32'h0000_1000 -> instr_err_o=1, rvalid=1, rdata=32'h13; with the macro undefined the same fetch returns word 0.
